mac_dot_ctrl: RTL and testbench
===============================

MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: operand buffer entries per vector.
REQ-002 SHALL have ports clk, input, 1, the single clock, all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port wr_en, input, 1: buffer write strobe.
REQ-005 SHALL have port wr_sel, input, 1: 0 writes buffer A, 1 writes buffer B.
REQ-006 SHALL have port wr_addr, input, 3: buffer index.
REQ-007 SHALL have port wr_data, input, 8 signed: operand value.
REQ-008 SHALL have port start, input, 1: launch a dot product.
REQ-009 SHALL have port len, input, 4: element count, sampled with start.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port result, output, 16 signed: last dot-product value.
REQ-013 SHALL have port mac_reset, output, 1: active-high clear to the MAC.
REQ-014 SHALL have ports mac_a and mac_b, output, 8 signed each: MAC operands.
REQ-015 SHALL have port mac_valid_in, output, 1: MAC input qualifier.
REQ-016 SHALL have port mac_f, input, 16 signed: MAC accumulator.
REQ-017 SHALL have port mac_valid_out, input, 1: MAC output qualifier; MAC latency is one cycle after the edge that samples mac_valid_in.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, ISSUE, DRAIN, DONE; all MAC-side outputs registered.
REQ-019 SHALL, in IDLE only, write wr_data into the selected buffer at wr_addr on wr_en; wr_en while busy is ignored.
REQ-020 SHALL, in IDLE with start=1, latch eff_len = min(len, DEPTH) and go to CLEAR if eff_len>0, else to DONE with result=0 and no MAC activity.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL, in CLEAR, drive mac_reset=1 for exactly one cycle, then enter ISSUE with index 0.
REQ-023 SHALL, in ISSUE, drive mac_valid_in=1 with mac_a=A[i], mac_b=B[i] for eff_len consecutive cycles, i = 0..eff_len-1, then enter DRAIN.
REQ-024 SHALL drive mac_valid_in=0, mac_a=0, mac_b=0 outside ISSUE.
REQ-025 SHALL count mac_valid_out pulses from CLEAR onward; in DRAIN, on the pulse bringing the count to eff_len, capture mac_f into result and enter DONE.
REQ-026 SHALL, if DRAIN lasts 8 cycles without reaching the count, set result=16'h8000 and enter DONE (timeout).
REQ-027 SHALL, in DONE, assert done=1 for one cycle, then return to IDLE; result holds until the next capture.
REQ-028 SHALL pass MAC 16-bit wraparound through unmodified (no saturation).
REQ-029 SHALL make start-to-first-mac_valid_in latency exactly 2 cycles and start-to-done latency eff_len+4 cycles for a one-cycle-latency MAC.

Reset
REQ-030 SHALL, while reset_n=0, force state IDLE, busy=0, done=0, result=0, mac_valid_in=0, mac_a=0, mac_b=0, mac_reset=1, counters and both buffers to 0.
REQ-031 SHALL deassert mac_reset on the first rising clk edge after reset_n rises.
REQ-032 SHALL, on reset_n asserted mid-operation, abandon the run with no done pulse.

Verification
REQ-033 SHALL pass: A=[1,2,3], B=[1,2,3], start len=3 -> one mac_reset pulse, 3 mac_valid_in cycles, done after 7 cycles, result=14.
REQ-034 SHALL pass: A=[-128,-128], B=[-128,127], len=2 -> result=128.
REQ-035 SHALL pass: A=B=[127,127,127], len=3 -> result=-17149 (wrapped 48387).
REQ-036 SHALL pass: len=0 -> done 2 cycles after start, result=0, mac_reset and mac_valid_in stay 0; len=12 -> exactly 8 issues.
REQ-037 SHALL pass: start during busy ignored, back-to-back runs each pulse mac_reset and the second result excludes the first sum.
REQ-038 SHALL pass: reset_n low during ISSUE -> busy=0, no done, mac_reset=1 immediately; MAC stubbed never asserting mac_valid_out -> result=16'h8000 after timeout.

Source files
------------

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: holds two operand vectors and streams them into an
// external one-cycle MAC, then captures the accumulated result.
module mac_dot_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [2:0]         wr_addr,
    input  logic signed [7:0]  wr_data,
    input  logic               start,
    input  logic [3:0]         len,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] result,
    output logic               mac_reset,
    output logic signed [7:0]  mac_a,
    output logic signed [7:0]  mac_b,
    output logic               mac_valid_in,
    input  logic signed [15:0] mac_f,
    input  logic               mac_valid_out
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0] eff_len_q, eff_len_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] drain_q, drain_d;

    logic signed [7:0] buf_a_q [DEPTH];
    logic signed [7:0] buf_a_d [DEPTH];
    logic signed [7:0] buf_b_q [DEPTH];
    logic signed [7:0] buf_b_d [DEPTH];

    logic               done_q, done_d;
    logic signed [15:0] result_q, result_d;
    logic               mac_reset_q, mac_reset_d;
    logic               mac_valid_in_q, mac_valid_in_d;
    logic signed [7:0]  mac_a_q, mac_a_d;
    logic signed [7:0]  mac_b_q, mac_b_d;

    always_comb begin
        state_d   = state_q;
        eff_len_d = eff_len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        result_d  = result_q;
        done_d    = (state_q == DONE);

        // MAC completions are counted from CLEAR onward so early pulses are not lost
        if ((state_q == CLEAR || state_q == ISSUE || state_q == DRAIN) && mac_valid_out) begin
            cnt_d = cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (wr_en && (32'(wr_addr) < DEPTH)) begin
                    if (wr_sel) begin
                        buf_b_d[wr_addr[AW-1:0]] = wr_data;
                    end else begin
                        buf_a_d[wr_addr[AW-1:0]] = wr_data;
                    end
                end
                if (start) begin
                    eff_len_d = (len > DEPTH_L) ? DEPTH_L : len;
                    cnt_d     = '0;
                    idx_d     = '0;
                    drain_d   = '0;
                    if (eff_len_d != 4'd0) begin
                        state_d = CLEAR;
                    end else begin
                        state_d  = DONE;
                        result_d = '0;
                    end
                end
            end
            CLEAR: begin
                state_d = ISSUE;
                idx_d   = '0;
            end
            ISSUE: begin
                if (idx_q == eff_len_q - 4'd1) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DRAIN: begin
                if (mac_valid_out && (cnt_q + 4'd1 == eff_len_q)) begin
                    result_d = mac_f;
                    state_d  = DONE;
                end else if (drain_q == 3'd7) begin
                    result_d = 16'sh8000;
                    state_d  = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // MAC-side outputs are registered from the upcoming state so they line up with it
        mac_reset_d    = (state_d == CLEAR);
        mac_valid_in_d = (state_d == ISSUE);
        mac_a_d        = mac_valid_in_d ? buf_a_q[idx_d[AW-1:0]] : '0;
        mac_b_d        = mac_valid_in_d ? buf_b_q[idx_d[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            eff_len_q      <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            drain_q        <= '0;
            done_q         <= 1'b0;
            result_q       <= '0;
            mac_reset_q    <= 1'b1;
            mac_valid_in_q <= 1'b0;
            mac_a_q        <= '0;
            mac_b_q        <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_a_q[i] <= '0;
                buf_b_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            eff_len_q      <= eff_len_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            drain_q        <= drain_d;
            done_q         <= done_d;
            result_q       <= result_d;
            mac_reset_q    <= mac_reset_d;
            mac_valid_in_q <= mac_valid_in_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_a_q[i] <= buf_a_d[i];
                buf_b_q[i] <= buf_b_d[i];
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign result       = result_q;
    assign mac_reset    = mac_reset_q;
    assign mac_valid_in = mac_valid_in_q;
    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Bench for mac_dot_ctrl: behavioural one-cycle MAC plus an arithmetic
// dot-product reference; directed and random runs checked with assertions.
module tb_mac_dot_ctrl;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               wr_en;
    logic               wr_sel;
    logic [2:0]         wr_addr;
    logic signed [7:0]  wr_data;
    logic               start;
    logic [3:0]         len;
    logic               busy;
    logic               done;
    logic signed [15:0] result;
    logic               mac_reset;
    logic signed [7:0]  mac_a;
    logic signed [7:0]  mac_b;
    logic               mac_valid_in;
    logic signed [15:0] mac_f;
    logic               mac_valid_out;

    int n_asserts = 0;
    int n_fail    = 0;
    bit stub      = 1'b0;
    int ma [8];
    int mb [8];

    always #5 clk = ~clk;

    mac_dot_ctrl #(.DEPTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mac_reset    (mac_reset),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_valid_in (mac_valid_in),
        .mac_f        (mac_f),
        .mac_valid_out(mac_valid_out)
    );

    // External MAC: accumulates on the edge that samples mac_valid_in
    always @(posedge clk) begin
        if (mac_reset) begin
            mac_f         <= '0;
            mac_valid_out <= 1'b0;
        end else begin
            mac_valid_out <= mac_valid_in && !stub;
            if (mac_valid_in) mac_f <= mac_f + mac_a * mac_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic signed [15:0] model_dot(input int ln);
        int eff = (ln > 8) ? 8 : ln;
        int s = 0;
        for (int i = 0; i < eff; i++) s += ma[i] * mb[i];
        return 16'(s);
    endfunction

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = 8'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) mb[addr] = data; else ma[addr] = data;
    endtask

    task automatic run_dot(input int ln, input bit poke);
        int eff = (ln > 8) ? 8 : ln;
        logic signed [15:0] exp_res = stub ? 16'sh8000 : model_dot(ln);
        int first_vi = -1;
        int n_vi = 0;
        int n_mr = 0;
        int done_c = -1;
        start = 1'b1;
        len   = 4'(ln);
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b0;
                chk("busy_after_start", 32'(busy), 1);
            end
            if (mac_reset) n_mr++;
            if (mac_valid_in) begin
                if (first_vi < 0) first_vi = c;
                if (n_vi < 8) begin
                    chk("mac_a", 32'(mac_a), ma[n_vi]);
                    chk("mac_b", 32'(mac_b), mb[n_vi]);
                end
                n_vi++;
            end
            if (done) done_c = c;
            if (poke && c == 3) begin
                start = 1'b1; len = 4'd1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 8'(~ma[0]);
            end
            if (poke && c == 4) begin
                start = 1'b0; wr_en = 1'b0;
            end
        end
        if (stub) begin
            chk("done_seen", 32'(done_c > 0), 1);
        end else begin
            chk("done_latency", done_c, (eff == 0) ? 2 : eff + 4);
            chk("first_valid_latency", first_vi, (eff == 0) ? -1 : 2);
        end
        chk("issue_count", n_vi, eff);
        chk("mac_reset_pulses", n_mr, (eff == 0) ? 0 : 1);
        chk("result", 32'(result), 32'(exp_res));
        @(posedge clk); #1;
        chk("done_single_pulse", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);
        chk("result_hold", 32'(result), 32'(exp_res));
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0;
        for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_valid_in", 32'(mac_valid_in), 0);
        chk("rst_mac_a", 32'(mac_a), 0);
        chk("rst_mac_b", 32'(mac_b), 0);
        chk("rst_mac_reset", 32'(mac_reset), 1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mac_reset_release", 32'(mac_reset), 0);

        for (int i = 0; i < 3; i++) begin wr(0, i, i + 1); wr(1, i, i + 1); end
        run_dot(3, 0);
        chk("dot_123", 32'(result), 32'(16'sd14));

        wr(0, 0, -128); wr(0, 1, -128); wr(1, 0, -128); wr(1, 1, 127);
        run_dot(2, 0);
        chk("dot_extremes", 32'(result), 32'(16'sd128));

        for (int i = 0; i < 3; i++) begin wr(0, i, 127); wr(1, i, 127); end
        run_dot(3, 0);
        chk("dot_wrap", 32'(result), 32'(-16'sd17149));

        run_dot(0, 0);

        // Busy-time start/write ignored, then a back-to-back run
        run_dot(3, 1);
        run_dot(2, 0);
        chk("back_to_back", 32'(result), 32'(16'sd32258));

        for (int i = 0; i < 8; i++) begin
            wr(0, i, int'($urandom_range(255)) - 128);
            wr(1, i, int'($urandom_range(255)) - 128);
        end
        run_dot(12, 0);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 8; i++) begin
                wr(0, i, int'($urandom_range(255)) - 128);
                wr(1, i, int'($urandom_range(255)) - 128);
            end
            run_dot(int'($urandom_range(15)), 0);
        end

        // Reset in the middle of ISSUE
        start = 1'b1; len = 4'd5;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_issue_valid", 32'(mac_valid_in), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_mac_reset", 32'(mac_reset), 1);
        chk("mid_rst_valid_in", 32'(mac_valid_in), 0);
        for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_done", 32'(done), 0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_no_done", 32'(done), 0);
        run_dot(3, 0);

        wr(0, 0, 5); wr(1, 0, 7); wr(0, 1, -3); wr(1, 1, 9);
        stub = 1'b1;
        run_dot(2, 0);
        chk("timeout_value", 32'(result), 32'(16'sh8000));
        stub = 1'b0;
        run_dot(2, 0);
        chk("after_timeout", 32'(result), 32'(16'sd8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
